// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: trap/irq entry with pipeline drain, nested
// {STATUS,EPC} save stack, eret unwind. Optional timer under `CP0_TIMER_EN`.
module cp0_exc_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter int          NEST_DEPTH = 2,
  parameter logic [31:0] VEC_ADDR   = 32'h00400004
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [31:0]        pc_cur,
  input  logic               exc_req,
  input  logic [4:0]         exc_cause,
  input  logic               eret,
  input  logic               mtc0,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_wdata,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               pipe_idle,
  output logic [31:0]        cp0_rdata,
  output logic               stall,
  output logic               flush,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        status_out,
  output logic [31:0]        cause_out,
  output logic [31:0]        epc_out
);
`ifdef CP0_TIMER_EN
  localparam int NI = NUM_IRQ + 1;
`else
  localparam int NI = NUM_IRQ;
`endif
  localparam int SW = 4 + NI;
  localparam int CW = $clog2(NEST_DEPTH + 1);
  localparam int IW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(NEST_DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] ENTER  = 2'd2;
  localparam logic [1:0] RETURN = 2'd3;

  logic [1:0]    state;
  logic [SW-1:0] status_q;
  logic [31:0]   epc_q, pc_lat;
  logic [4:0]    code_q, code_lat;
  logic          ovf, unf;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stk_status [NEST_DEPTH];
  logic [31:0]   stk_epc    [NEST_DEPTH];
  logic [NI-1:0] pend;
  logic          trap_en, trap_ok, irq_ok, full, idle, take, blocked, do_eret, do_mtc0;
  logic [IW-1:0] push_idx, pop_idx;

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, compare_q;
  logic        tpend;
  assign pend = {tpend, irq};
`else
  assign pend = irq;
`endif

  // Codes without a dedicated mask bit (e.g. overflow) are never maskable.
  always_comb begin
    trap_en = 1'b1;
    case (exc_cause)
      5'd8:    trap_en = status_q[1];
      5'd9:    trap_en = status_q[2];
      5'd13:   trap_en = status_q[3];
      default: trap_en = 1'b1;
    endcase
  end

  assign idle     = (state == IDLE);
  assign full     = (cnt == FULL);
  assign trap_ok  = instr_valid & exc_req & status_q[0] & trap_en;
  assign irq_ok   = instr_valid & status_q[0] & (|(pend & status_q[4 +: NI]));
  assign take     = idle & (trap_ok | irq_ok) & ~full;
  assign blocked  = idle & (trap_ok | irq_ok) & full;
  assign do_eret  = idle & instr_valid & eret & ~take;
  assign do_mtc0  = idle & instr_valid & mtc0 & ~take;
  assign push_idx = IW'(cnt);
  assign pop_idx  = IW'(cnt - CW'(1));

  assign flush          = take | do_eret;
  assign stall          = take | (state == DRAIN);
  assign redirect_valid = (state == ENTER) | (state == RETURN);
  assign redirect_pc    = (state == ENTER) ? VEC_ADDR : (state == RETURN) ? epc_q : 32'd0;
  assign status_out     = 32'(status_q);
  assign epc_out        = epc_q;

  always_comb begin
    cause_out          = '0;
    cause_out[31]      = ovf;
    cause_out[30]      = unf;
    cause_out[8 +: NI] = pend;
    cause_out[6:2]     = code_q;
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      5'd12: cp0_rdata = status_out;
      5'd13: cp0_rdata = cause_out;
      5'd14: cp0_rdata = epc_q;
`ifdef CP0_TIMER_EN
      5'd9:  cp0_rdata = count_q;
      5'd11: cp0_rdata = compare_q;
`endif
      default: cp0_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      status_q <= '0;
      epc_q    <= '0;
      pc_lat   <= '0;
      code_q   <= '0;
      code_lat <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (do_mtc0) begin
            case (cp0_addr)
              5'd12: status_q <= cp0_wdata[SW-1:0];
              5'd13: begin ovf <= cp0_wdata[31]; unf <= cp0_wdata[30]; end
              5'd14: epc_q <= cp0_wdata;
              default: ;
            endcase
          end
          if (blocked) ovf <= 1'b1;
          if (take) begin
            pc_lat   <= pc_cur;
            code_lat <= trap_ok ? exc_cause : 5'd0;
            state    <= DRAIN;
          end else if (do_eret) begin
            state <= RETURN;
          end
        end
        DRAIN: if (pipe_idle) state <= ENTER;
        ENTER: begin
          epc_q       <= pc_lat;
          code_q      <= code_lat;
          status_q[0] <= 1'b0;
          cnt         <= cnt + CW'(1);
          state       <= IDLE;
        end
        RETURN: begin
          if (cnt != '0) begin
            status_q <= stk_status[pop_idx];
            epc_q    <= stk_epc[pop_idx];
            cnt      <= cnt - CW'(1);
          end else begin
            unf <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stk_status[i] <= '0;
        stk_epc[i]    <= '0;
      end
    end else if (state == ENTER) begin
      stk_status[push_idx] <= status_q;
      stk_epc[push_idx]    <= epc_q;
    end
  end

`ifdef CP0_TIMER_EN
  // Compare write clears pending and wins over a same-cycle match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      tpend     <= 1'b0;
    end else begin
      count_q <= (do_mtc0 && cp0_addr == 5'd9) ? cp0_wdata : count_q + 32'd1;
      if (do_mtc0 && cp0_addr == 5'd11) begin
        compare_q <= cp0_wdata;
        tpend     <= 1'b0;
      end else if (count_q == compare_q) begin
        tpend <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: reset, trap entry timing, masking, priority,
// nesting/unwind and (with CP0_TIMER_EN) the timer interrupt.
module tb_cp0_exc_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        instr_valid, exc_req, eret, mtc0, pipe_idle;
  logic [31:0] pc_cur, cp0_wdata;
  logic [4:0]  exc_cause, cp0_addr;
  logic [3:0]  irq;
  logic [31:0] cp0_rdata, redirect_pc, status_out, cause_out, epc_out;
  logic        stall, flush, redirect_valid;
  int          total = 0, passed = 0;

  cp0_exc_ctrl #(.NUM_IRQ(4), .NEST_DEPTH(2), .VEC_ADDR(32'h00400004)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc_cur(pc_cur),
    .exc_req(exc_req), .exc_cause(exc_cause), .eret(eret), .mtc0(mtc0),
    .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .irq(irq), .pipe_idle(pipe_idle),
    .cp0_rdata(cp0_rdata), .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .status_out(status_out), .cause_out(cause_out),
    .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    instr_valid = 0; exc_req = 0; exc_cause = 0; eret = 0; mtc0 = 0;
    cp0_addr = 0; cp0_wdata = 0; pc_cur = 0; pipe_idle = 0;
  endtask

  task automatic do_reset();
    clr(); irq = 0; rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    instr_valid = 1; mtc0 = 1; cp0_addr = a; cp0_wdata = d;
    tick(); clr();
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cp0_addr = a; #1; d = cp0_rdata;
  endtask

  // Issue a taken trap/irq with pipe already idle; returns after ENTER completes.
  task automatic take_seq(input string tag, input logic [31:0] pc, input logic req,
                          input logic [4:0] code);
    instr_valid = 1; pc_cur = pc; exc_req = req; exc_cause = code; pipe_idle = 1;
    #1 chk({tag, "_flush"}, 32'(flush), 32'd1);
    tick(); clr(); pipe_idle = 1;
    tick();
    chk({tag, "_vec"}, redirect_pc, 32'h00400004);
    tick(); clr();
  endtask

  task automatic eret_seq(input string tag, input logic [31:0] exp_pc);
    instr_valid = 1; eret = 1;
    #1 chk({tag, "_flush"}, 32'(flush), 32'd1);
    tick(); clr();
    chk({tag, "_rv"}, 32'(redirect_valid), 32'd1);
    chk({tag, "_rpc"}, redirect_pc, exp_pc);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int n;
    // 1: reset asserted mid-DRAIN
    do_reset();
    wr(5'd12, 32'h3);
    instr_valid = 1; exc_req = 1; exc_cause = 5'd8; pc_cur = 32'h00400100;
    tick(); clr();
    chk("drain_stall", 32'(stall), 32'd1);
    rst_n = 0; #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_rv", 32'(redirect_valid), 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_status", status_out, 32'd0);
    chk("rst_cause", cause_out, 32'd0);
    chk("rst_epc", epc_out, 32'd0);
    rd(5'd12, v); chk("rst_rd12", v, 32'd0);
    tick(); rst_n = 1; pipe_idle = 1;
    tick();
    chk("post_rst_rv", 32'(redirect_valid), 32'd0);
    chk("post_rst_stall", 32'(stall), 32'd0);
    clr();

    // 2: syscall entry timing
    instr_valid = 1; mtc0 = 1; cp0_addr = 5'd12; cp0_wdata = 32'h3;
    #1 chk("mfc0_old", cp0_rdata, 32'd0);
    tick(); clr();
    chk("status_wr", status_out, 32'h3);
    instr_valid = 1; exc_req = 1; exc_cause = 5'd8; pc_cur = 32'h00400100;
    #1 chk("sys_flush0", 32'(flush), 32'd1);
    chk("sys_stall0", 32'(stall), 32'd1);
    tick(); clr();
    chk("sys_flush1", 32'(flush), 32'd0);
    chk("sys_stall1", 32'(stall), 32'd1);
    tick(); pipe_idle = 1;
    chk("sys_stall2", 32'(stall), 32'd1);
    tick(); clr();
    chk("sys_stall3", 32'(stall), 32'd0);
    chk("sys_rv", 32'(redirect_valid), 32'd1);
    chk("sys_rpc", redirect_pc, 32'h00400004);
    tick();
    chk("sys_rv_off", 32'(redirect_valid), 32'd0);
    chk("sys_epc", epc_out, 32'h00400100);
    chk("sys_cause", cause_out, 32'h20);
    chk("sys_status", status_out, 32'h2);
    rd(5'd14, v); chk("sys_rd14", v, 32'h00400100);

    // 3: masked break
    wr(5'd12, 32'h1);
    instr_valid = 1; exc_req = 1; exc_cause = 5'd9; pc_cur = 32'h00400180;
    #1 chk("brk_flush", 32'(flush), 32'd0);
    chk("brk_stall", 32'(stall), 32'd0);
    tick(); clr();
    chk("brk_rv", 32'(redirect_valid), 32'd0);
    chk("brk_cause", cause_out, 32'h20);

    // 4: trap beats irq; irq0 taken after eret
    do_reset();
    wr(5'd12, 32'h31);
    irq = 4'b0011; #1;
    chk("irq_live", cause_out, 32'h300);
    take_seq("pri_trap", 32'h00400200, 1'b1, 5'd12);
    chk("pri_cause", cause_out, 32'h330);
    chk("pri_epc", epc_out, 32'h00400200);
    chk("pri_status", status_out, 32'h30);
    eret_seq("pri_eret", 32'h00400200);
    chk("pri_ret_status", status_out, 32'h31);
    take_seq("pri_irq", 32'h00400300, 1'b0, 5'd0);
    chk("pri_irq_cause", cause_out, 32'h300);
    chk("pri_irq_epc", epc_out, 32'h00400300);

    // 5: nesting, overflow, LIFO unwind, underflow
    do_reset();
    wr(5'd12, 32'h11);
    irq = 4'b0001;
    take_seq("nest1", 32'h1000, 1'b0, 5'd0);
    wr(5'd12, 32'h11);
    take_seq("nest2", 32'h2000, 1'b0, 5'd0);
    chk("nest2_epc", epc_out, 32'h2000);
    wr(5'd12, 32'h11);
    instr_valid = 1; pc_cur = 32'h3000;
    #1 chk("ovf_flush", 32'(flush), 32'd0);
    tick(); clr();
    chk("ovf_rv", 32'(redirect_valid), 32'd0);
    chk("ovf_cause", cause_out, 32'h80000100);
    irq = 4'b0000;
    wr(5'd13, 32'h0);
    chk("cause_clr", cause_out, 32'h0);
    eret_seq("ret1", 32'h2000);
    chk("ret1_status", status_out, 32'h11);
    chk("ret1_epc", epc_out, 32'h1000);
    eret_seq("ret2", 32'h1000);
    chk("ret2_status", status_out, 32'h11);
    chk("ret2_epc", epc_out, 32'h0);
    eret_seq("ret3", 32'h0);
    chk("unf_cause", cause_out, 32'h40000000);
    chk("unf_status", status_out, 32'h11);

`ifdef CP0_TIMER_EN
    // 6: timer pending at Count==Compare, cleared by Compare write
    do_reset();
    wr(5'd11, 32'd20);
    chk("tmr_clr0", 32'(cause_out[12]), 32'd0);
    n = 0;
    while (!cause_out[12] && n < 60) begin tick(); n++; end
    chk("tmr_pend", 32'(cause_out[12]), 32'd1);
    rd(5'd9, v); chk("tmr_count", v, 32'd21);
    wr(5'd11, 32'd1000);
    chk("tmr_clr1", 32'(cause_out[12]), 32'd0);
`else
    wr(5'd9, 32'd5);
    wr(5'd11, 32'd7);
    rd(5'd9, v);  chk("no_count", v, 32'd0);
    rd(5'd11, v); chk("no_compare", v, 32'd0);
    n = 0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
